alu_sequencer: RTL and testbench
================================

# alu_sequencer

Hardware initiator for the combinational 32-bit MIPS-subset ALU. Accepts one instruction word plus register operand values per handshake, decodes opcode/funct, and drives the ALU operand and control inputs. It waits a fixed settle window for the ALU's ripple logic, captures the result and flags, and returns them with a branch decision. Sits between the register-read stage and writeback/branch logic.

## Interface
- SETTLE_CYCLES, 4, cycles the ALU inputs are held before capture; legal range 1..255
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- instr  in  32  instruction word: [31:26] opcode, [5:0] funct, [15:0] imm
- rs_val  in  32  first register operand
- rt_val  in  32  second register operand
- alu_a  out  32  ALU operandA
- alu_b  out  32  ALU operandB
- alu_opcode  out  6  ALU opcode
- alu_funct  out  6  ALU funct
- alu_res  in  32  ALU result
- alu_zero, alu_overflow, alu_carryout  in  1 each  ALU flags
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  32  captured result
- out_zero, out_overflow, out_carryout  out  1 each  captured flags
- out_branch_taken  out  1  branch decision (BEQ/BNE only, else 0)
- out_illegal  out  1  unsupported opcode/funct

## Operation
- Encodings: RTYPE 0x00, ADDI 0x08, XORI 0x0E, BEQ 0x04, BNE 0x05; funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- Supported: RTYPE with ADD/SUB/SLT, ADDI, XORI, BEQ, BNE. Anything else is illegal.
- Decode on acceptance (in_valid && in_ready), registered into alu_* outputs:
  - alu_a = rs_val.
  - alu_b = rt_val for RTYPE/BEQ/BNE; sign-extended imm for ADDI; zero-extended imm for XORI.
  - alu_opcode = instr[31:26].
  - alu_funct = instr[5:0] for RTYPE, 0x08 (JR) otherwise.
- FSM states:
  - IDLE: in_ready=1. Legal accept -> SETTLE with counter=SETTLE_CYCLES-1. Illegal accept -> DONE with out_illegal=1, out_res=0, all flags 0, out_branch_taken=0; alu_* unchanged.
  - SETTLE: counter decrements each edge. At counter==0 the next edge captures alu_res and flags into out_*, computes out_branch_taken (BEQ: alu_zero; BNE: !alu_zero; else 0), and moves to DONE.
  - DONE: out_valid=1. out_valid && out_ready -> IDLE.
- in_valid outside IDLE is ignored; instr/rs_val/rt_val are sampled only at acceptance.
- Flags are passed through verbatim; no arithmetic is done locally except imm extension.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, all out_* and alu_* outputs 0, counter 0. Takes effect immediately, including mid-SETTLE or DONE; any pending result is discarded.
- Legal latency: accept at edge E; alu_* valid after E; capture at edge E+SETTLE_CYCLES; out_valid high after that edge.
- Illegal latency: out_valid high after the acceptance edge itself (1 cycle).
- Handshake completes at an edge with out_valid && out_ready. out_valid drops after that edge and in_ready rises in the same cycle. Acceptance is not possible in the cycle of completion.
- Max throughput: one legal op per SETTLE_CYCLES+2 cycles.
- Backpressure: while out_valid && !out_ready, all out_* outputs and alu_* outputs hold stable indefinitely.
- alu_* outputs hold their last values between operations.

## Test plan
- ADDI: rs_val=7000, imm=0x36B0, SETTLE_CYCLES=4 -> out_valid 4 cycles after accept; out_res=21000, overflow=0, carryout=0, illegal=0.
- ADDI sign extension: rs_val=1, imm=0xFFFF -> alu_b=0xFFFFFFFF; out_res=0, zero=1, carryout=1. XORI with imm=0xFFFF -> alu_b=0x0000FFFF.
- RTYPE SUB: rs_val=0x80000004, rt_val=0x7FFFFFFC -> out_res=8, overflow=1, carryout=1. RTYPE SLT: rs_val=0xDA00_0084, rt_val=1000 -> out_res=1.
- BEQ and BNE with rs_val=rt_val=637483644: BEQ -> zero=1, branch_taken=1. BNE -> branch_taken=0. BNE with rt_val=637483643 -> branch_taken=1.
- Backpressure: hold out_ready low 10 cycles after out_valid -> out_* and in_ready=0 remain stable, and a second in_valid is ignored. Raise out_ready -> in_ready high the next cycle and the new request is accepted.
- Illegal and reset:
  - opcode 0x3F -> out_valid one cycle after accept, with out_illegal=1 and out_res=0.
  - rst_n pulsed low during SETTLE -> out_valid=0 and alu_*=0 immediately; in_ready=1; no stale result is emitted afterward.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Groups every non-clock signal of the ALU sequencer:
//   - request side : in_valid/in_ready handshake, instr, rs_val, rt_val
//   - ALU side     : alu_a/alu_b/alu_opcode/alu_funct driven to the
//                    combinational ALU, alu_res + flags returned from it
//   - result side  : out_valid/out_ready handshake, captured result,
//                    flags, branch decision, illegal marker
//   slave  : the sequencer itself
//   master : the surrounding environment (register-read stage, ALU,
//            writeback/branch consumer)
interface alu_sequencer_if;
  // request
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  // ALU drive / return
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carryout;
  // result
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic        out_overflow;
  logic        out_carryout;
  logic        out_branch_taken;
  logic        out_illegal;

  modport slave (
    input  in_valid, instr, rs_val, rt_val,
    input  alu_res, alu_zero, alu_overflow, alu_carryout,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_opcode, alu_funct,
    output out_valid, out_res, out_zero, out_overflow, out_carryout,
    output out_branch_taken, out_illegal
  );

  modport master (
    output in_valid, instr, rs_val, rt_val,
    output alu_res, alu_zero, alu_overflow, alu_carryout,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_opcode, alu_funct,
    input  out_valid, out_res, out_zero, out_overflow, out_carryout,
    input  out_branch_taken, out_illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Initiator for a combinational 32-bit MIPS-subset ALU. Takes one
//   instruction plus register operands per handshake, decodes it into
//   registered ALU operand/control outputs, holds them for SETTLE_CYCLES
//   while the ALU ripple logic settles, then captures result and flags
//   and presents them with a branch decision until the consumer accepts.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_sequencer_if.slave (request, ALU drive/return, result)
// Parameters
//   SETTLE_CYCLES : cycles alu_* are held before capture, 1..255
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        overflow;
    logic        carryout;
    logic        branch_taken;
    logic        illegal;
  } rsp_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;

  logic [31:0] alu_a_q, alu_b_q;
  logic [5:0]  alu_opcode_q, alu_funct_q;
  rsp_t        rsp_q;

  // ---------------- decode ----------------
  logic [5:0]  opc, fn;
  logic [15:0] imm;
  logic        legal;
  logic [31:0] b_dec;
  logic [5:0]  fn_dec;
  logic        accept;
  logic        capture;

  // rs/rt fields and shamt are not needed: operands arrive as values.
  logic        unused_fields;
  assign unused_fields = ^bus.instr[25:16];

  assign opc = bus.instr[31:26];
  assign fn  = bus.instr[5:0];
  assign imm = bus.instr[15:0];

  always_comb begin
    legal  = 1'b0;
    b_dec  = bus.rt_val;
    fn_dec = FN_JR;
    case (opc)
      OP_RTYPE: begin
        fn_dec = fn;
        legal  = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
      end
      OP_ADDI: begin
        b_dec = {{16{imm[15]}}, imm};
        legal = 1'b1;
      end
      OP_XORI: begin
        b_dec = {16'h0000, imm};
        legal = 1'b1;
      end
      OP_BEQ, OP_BNE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign accept  = bus.in_valid && (state == IDLE);
  assign capture = (state == SETTLE) && (cnt == 8'd0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? SETTLE : DONE;
      SETTLE:  if (cnt == 8'd0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loaded with SETTLE_CYCLES-1 so the capture edge lands exactly
  // SETTLE_CYCLES edges after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= 8'd0;
    else if (accept && legal)         cnt <= CNT_LOAD;
    else if (state == SETTLE && cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  // ALU drive registers: only a legal accept updates them, so illegal
  // requests and idle periods leave the last operation on the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_funct_q  <= '0;
    end else if (accept && legal) begin
      alu_a_q      <= bus.rs_val;
      alu_b_q      <= b_dec;
      alu_opcode_q <= opc;
      alu_funct_q  <= fn_dec;
    end
  end

  // Result register. alu_opcode_q still holds the in-flight op at
  // capture, so the branch decision keys off it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else if (accept && !legal) begin
      rsp_q         <= '0;
      rsp_q.illegal <= 1'b1;
    end else if (capture) begin
      rsp_q.res          <= bus.alu_res;
      rsp_q.zero         <= bus.alu_zero;
      rsp_q.overflow     <= bus.alu_overflow;
      rsp_q.carryout     <= bus.alu_carryout;
      rsp_q.illegal      <= 1'b0;
      rsp_q.branch_taken <= (alu_opcode_q == OP_BEQ) ?  bus.alu_zero :
                            (alu_opcode_q == OP_BNE) ? !bus.alu_zero : 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign bus.in_ready         = (state == IDLE);
  assign bus.out_valid        = (state == DONE);
  assign bus.alu_a            = alu_a_q;
  assign bus.alu_b            = alu_b_q;
  assign bus.alu_opcode       = alu_opcode_q;
  assign bus.alu_funct        = alu_funct_q;
  assign bus.out_res          = rsp_q.res;
  assign bus.out_zero         = rsp_q.zero;
  assign bus.out_overflow     = rsp_q.overflow;
  assign bus.out_carryout     = rsp_q.carryout;
  assign bus.out_branch_taken = rsp_q.branch_taken;
  assign bus.out_illegal      = rsp_q.illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural combinational ALU standing in for the real one.
  logic [32:0] sum;
  always_comb begin
    sum              = '0;
    bus.alu_res      = '0;
    bus.alu_overflow = 1'b0;
    bus.alu_carryout = 1'b0;
    case (bus.alu_opcode)
      6'h00: begin
        if (bus.alu_funct == 6'h20) begin
          sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
          bus.alu_res = sum[31:0];
          bus.alu_carryout = sum[32];
          bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
        end else if (bus.alu_funct == 6'h22) begin
          sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
          bus.alu_res = sum[31:0];
          bus.alu_carryout = sum[32];
          bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
        end else if (bus.alu_funct == 6'h2A) begin
          bus.alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
        end
      end
      6'h08: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_res = sum[31:0];
        bus.alu_carryout = sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      6'h0E: bus.alu_res = bus.alu_a ^ bus.alu_b;
      6'h04, 6'h05: begin
        sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_res = sum[31:0];
        bus.alu_carryout = sum[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      default: ;
    endcase
    bus.alu_zero = (bus.alu_res == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input string tag, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt);
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                         input logic o, input logic c, input logic br, input logic ill);
    chk({tag, " res"}, bus.out_res, res);
    chk({tag, " flags"},
        {27'd0, bus.out_zero, bus.out_overflow, bus.out_carryout, bus.out_branch_taken, bus.out_illegal},
        {27'd0, z, o, c, br, ill});
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " drop valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " ready back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  initial begin
    int vcount;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.out_ready = 1'b0;

    // reset state
    #2;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst out_res", bus.out_res, 32'd0);
    chk("rst alu_a", bus.alu_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI 7000 + 14000
    issue("addi", itype(6'h08, 16'h36B0), 32'd7000, 32'd0);
    chk("addi alu_a", bus.alu_a, 32'd7000);
    chk("addi alu_b", bus.alu_b, 32'h0000_36B0);
    chk("addi alu_funct", {26'd0, bus.alu_funct}, 32'h08);
    wait_out("addi", SETTLE);
    chk_out("addi", 32'd21000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("addi");

    // ADDI sign extension
    issue("addi_sx", itype(6'h08, 16'hFFFF), 32'd1, 32'd0);
    chk("addi_sx alu_b", bus.alu_b, 32'hFFFF_FFFF);
    wait_out("addi_sx", SETTLE);
    chk_out("addi_sx", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    release_out("addi_sx");

    // XORI zero extension
    issue("xori", itype(6'h0E, 16'hFFFF), 32'd1, 32'd0);
    chk("xori alu_b", bus.alu_b, 32'h0000_FFFF);
    chk("xori alu_opcode", {26'd0, bus.alu_opcode}, 32'h0E);
    wait_out("xori", SETTLE);
    chk_out("xori", 32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("xori");

    // SUB with signed overflow
    issue("sub", rtype(6'h22), 32'h8000_0004, 32'h7FFF_FFFC);
    chk("sub alu_funct", {26'd0, bus.alu_funct}, 32'h22);
    chk("sub alu_b", bus.alu_b, 32'h7FFF_FFFC);
    wait_out("sub", SETTLE);
    chk_out("sub", 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    release_out("sub");

    // SLT negative vs positive
    issue("slt", rtype(6'h2A), 32'hDA00_0084, 32'd1000);
    wait_out("slt", SETTLE);
    chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("slt");

    // branches
    issue("beq_eq", itype(6'h04, 16'h0010), 32'd637483644, 32'd637483644);
    chk("beq alu_funct", {26'd0, bus.alu_funct}, 32'h08);
    wait_out("beq_eq", SETTLE);
    chk_out("beq_eq", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    release_out("beq_eq");

    issue("bne_eq", itype(6'h05, 16'h0010), 32'd637483644, 32'd637483644);
    wait_out("bne_eq", SETTLE);
    chk_out("bne_eq", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    release_out("bne_eq");

    issue("bne_ne", itype(6'h05, 16'h0010), 32'd637483644, 32'd637483643);
    wait_out("bne_ne", SETTLE);
    chk_out("bne_ne", 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    release_out("bne_ne");

    // illegal opcode: 1-cycle turnaround, ALU drive untouched
    issue("ill_op", itype(6'h3F, 16'h1234), 32'hDEAD_BEEF, 32'h1);
    wait_out("ill_op", 0);
    chk_out("ill_op", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ill_op alu_opcode", {26'd0, bus.alu_opcode}, 32'h05);
    chk("ill_op alu_a", bus.alu_a, 32'd637483644);
    release_out("ill_op");

    // illegal RTYPE funct (JR)
    issue("ill_jr", rtype(6'h08), 32'd3, 32'd4);
    wait_out("ill_jr", 0);
    chk_out("ill_jr", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    release_out("ill_jr");

    // backpressure: ADD 5+6 held while a new request waits
    issue("bp", rtype(6'h20), 32'd5, 32'd6);
    wait_out("bp", SETTLE);
    chk_out("bp", 32'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.instr    = itype(6'h08, 16'h0001);
    bus.rs_val   = 32'd100;
    bus.rt_val   = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp hold valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp hold ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp hold res", bus.out_res, 32'd11);
      chk("bp hold alu_a", bus.alu_a, 32'd5);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp done valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp done ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp2 alu_a", bus.alu_a, 32'd100);
    wait_out("bp2", SETTLE);
    chk_out("bp2", 32'd101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("bp2");

    // asynchronous reset mid-SETTLE
    issue("rst_mid", itype(6'h08, 16'h36B0), 32'd7000, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_mid alu_a", bus.alu_a, 32'd0);
    chk("rst_mid alu_b", bus.alu_b, 32'd0);
    chk("rst_mid out_res", bus.out_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("rst_mid stale valid", 32'(vcount), 32'd0);

    // normal operation after reset
    issue("post_rst", itype(6'h04, 16'h0001), 32'd9, 32'd9);
    wait_out("post_rst", SETTLE);
    chk_out("post_rst", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    release_out("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
